mmio_timer: RTL and testbench
=============================

Name: mmio_timer

Overview:
- Memory-mapped down-counting timer on the CPU data-memory port, in parallel with the data memory.
- Decodes the 8-bit word address, the write data and the memRead/memWrite strobes produced by the single-cycle core.
- Returns read data combinationally, as the data memory does, and asserts `hit` so the SoC can select timer data over memory data on the register-file write-back path.
- Provides a programmable period, a prescaler, one-shot or auto-reload operation, and a sticky expiry flag.

Parameters:
- BASE_ADDR, 8'hFC: word address of the 4-word register window; bits [1:0] are ignored and taken as 0.
- PRESCALE_W, 8: width of the prescaler field and of the prescaler counter.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- addr, input, 8: word address, equal to aluResult[9:2].
- writeData, input, 32: store data, equal to rfData2.
- memWrite, input, 1: store strobe.
- memRead, input, 1: load strobe.
- readData, output, 32: register read data.
- hit, output, 1: combinational; high when addr[7:2]==BASE_ADDR[7:2].
- irq, output, 1: interrupt request; see Optional Feature.

Behaviour:
- Register offset is addr[1:0].
  - 0 CTRL: bit0 EN, bit1 AUTO, bit2 IE, bits[8+PRESCALE_W-1:8] PRESC. Other bits read 0 and are ignored on write.
  - 1 LOAD: 32-bit reload value.
  - 2 COUNT: current count. A write loads the count and clears the prescaler counter.
  - 3 STATUS: bit0 EXPIRED, sticky, write-1-to-clear. bit1 RUNNING, read-only, mirrors EN. Other bits 0.
- Reset: all registers 0, prescaler counter 0, irq 0. Reset is honoured at any point, including mid-count.
- Reads are combinational. readData = selected register when memRead & hit, else 32'd0. No wait states.
- Writes occur on the rising edge when memWrite & hit. memWrite when hit=0 has no effect.
- Prescaler: while EN=1 it increments every cycle. When it equals PRESC, it wraps to 0 and a tick is generated. While EN=0 the prescaler counter holds at 0.
- On a tick:
  - COUNT != 0: COUNT <= COUNT-1.
  - COUNT == 0: EXPIRED <= 1.
    - AUTO=1: COUNT <= LOAD.
    - AUTO=0: EN <= 0 (one-shot; COUNT stays 0).
- Resulting period is (LOAD+1)*(PRESC+1) cycles from the point COUNT was loaded with LOAD.
- A CTRL write taking EN from 0 to 1 clears the prescaler counter. The first tick occurs PRESC+1 cycles later.
- Simultaneous events, all resolved on the same edge:
  - Bus write to COUNT plus tick: bus value wins and the tick is discarded.
  - STATUS W1C plus expiry: set wins, EXPIRED stays 1.
  - CTRL write plus hardware one-shot clear of EN: the bus-written EN wins.
  - LOAD write plus auto-reload: COUNT takes the old LOAD value.
- Wrap-around: COUNT never underflows below 0. PRESC=0 means a tick every enabled cycle.
- Latency: a written value is visible on readData in the cycle after the write edge.

Optional Feature:
- Macro: MMIO_TIMER_IRQ_EN.
- Defined: irq is a register, reset 0, updated every edge to EXPIRED_next & IE_next. irq therefore rises on the edge that sets EXPIRED (when IE=1) and falls on the edge after the W1C clear or the IE clear.
- Undefined: irq is tied to 0, the IE bit is not implemented and reads 0, and CTRL bit2 writes are ignored.

Test Plan:
- Reset during counting (EN=1, COUNT=5): assert rst asynchronously mid-cycle -> all registers read 0 immediately and irq=0.
- One-shot: LOAD=3, COUNT=3, CTRL=0x01 (PRESC=0) -> COUNT reads 2,1,0 on successive cycles; EXPIRED=1 one cycle after COUNT reaches 0; EN clears; STATUS=0x1.
- Auto-reload with prescale: LOAD=2, COUNT=2, CTRL=0x0203 -> EXPIRED first sets 9 cycles after enable; COUNT reads 2 again on that edge; the period repeats every 9 cycles.
- W1C race: write STATUS=1 on the same edge as an expiry tick -> EXPIRED stays 1. A second write STATUS=1 with no tick -> STATUS reads 0x2 (running, not expired).
- Decode: write 0xDEADBEEF to addr 8'hF8 (miss) -> hit=0, no register changes, readData=0. Write to 8'hFD -> LOAD reads 0xDEADBEEF. A read with memRead=0 -> readData=0.
- With MMIO_TIMER_IRQ_EN: CTRL=0x05, LOAD=COUNT=1 -> irq rises with EXPIRED two cycles after enable; writing STATUS=1 -> irq falls on the next edge. Without the macro, irq stays 0 and CTRL reads 0x01.

Source files
------------

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with prescaler, one-shot/auto-reload and sticky expiry flag.
// Reads are combinational, writes land on the clock edge, no wait states; optional irq via `MMIO_TIMER_IRQ_EN.
module mmio_timer #(
    parameter logic [7:0] BASE_ADDR  = 8'hFC,
    parameter int         PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic [31:0] writeData,
    input  logic        memWrite,
    input  logic        memRead,
    output logic [31:0] readData,
    output logic        hit,
    output logic        irq
);

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    logic                  en_q, en_d;
    logic                  auto_q, auto_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d;
    logic [31:0]           load_q, load_d;
    logic [31:0]           count_q, count_d;
    logic                  expired_q, expired_d;
    logic                  ie_cur;

    logic wr_en, wr_ctrl, wr_load, wr_count, wr_status;
    logic tick, expire_set;

    assign hit       = (addr[7:2] == BASE_ADDR[7:2]);
    assign wr_en     = memWrite & hit;
    assign wr_ctrl   = wr_en & (addr[1:0] == OFF_CTRL);
    assign wr_load   = wr_en & (addr[1:0] == OFF_LOAD);
    assign wr_count  = wr_en & (addr[1:0] == OFF_COUNT);
    assign wr_status = wr_en & (addr[1:0] == OFF_STATUS);

    // A bus write to COUNT on a tick edge swallows the tick completely, expiry included.
    assign tick       = en_q & (psc_q == presc_q);
    assign expire_set = tick & ~wr_count & (count_q == 32'd0);

`ifdef MMIO_TIMER_IRQ_EN
    logic ie_q, ie_d;
    logic irq_q, irq_d;

    assign ie_cur = ie_q;
    assign irq    = irq_q;
`else
    assign ie_cur = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        en_d      = en_q;
        auto_d    = auto_q;
        presc_d   = presc_q;
        load_d    = load_q;
        count_d   = count_q;
        psc_d     = '0;
`ifdef MMIO_TIMER_IRQ_EN
        ie_d      = ie_q;
`endif

        if (en_q && !tick) begin
            psc_d = psc_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end

        if (tick && !wr_count) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (auto_q) begin
                count_d = load_q;
            end else begin
                en_d = 1'b0;
            end
        end

        if (wr_ctrl) begin
            en_d    = writeData[0];
            auto_d  = writeData[1];
            presc_d = writeData[8 +: PRESCALE_W];
`ifdef MMIO_TIMER_IRQ_EN
            ie_d    = writeData[2];
`endif
            if (!en_q) begin
                psc_d = '0;
            end
        end

        if (wr_load) begin
            load_d = writeData;
        end

        if (wr_count) begin
            count_d = writeData;
            psc_d   = '0;
        end

        // Set beats clear when W1C and expiry coincide.
        expired_d = (expired_q & ~(wr_status & writeData[0])) | expire_set;

        if (!en_d) begin
            psc_d = '0;
        end
    end

`ifdef MMIO_TIMER_IRQ_EN
    always_comb begin
        irq_d = expired_d & ie_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            presc_q   <= '0;
            psc_q     <= '0;
            load_q    <= 32'd0;
            count_q   <= 32'd0;
            expired_q <= 1'b0;
        end else begin
            en_q      <= en_d;
            auto_q    <= auto_d;
            presc_q   <= presc_d;
            psc_q     <= psc_d;
            load_q    <= load_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

`ifdef MMIO_TIMER_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end
`endif

    always_comb begin
        readData = 32'd0;
        if (memRead && hit) begin
            case (addr[1:0])
                OFF_CTRL: begin
                    readData[0]               = en_q;
                    readData[1]               = auto_q;
                    readData[2]               = ie_cur;
                    readData[8 +: PRESCALE_W] = presc_q;
                end
                OFF_LOAD:   readData = load_q;
                OFF_COUNT:  readData = count_q;
                OFF_STATUS: readData = {30'd0, en_q, expired_q};
                default:    readData = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Randomized and directed bench for mmio_timer against a rule-level reference model.
module tb_mmio_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readData;
    logic        hit;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] last_rd;
    logic        last_irq;

    // Reference state, named after the architectural registers.
    logic        m_en, m_auto, m_ie, m_exp;
    logic [7:0]  m_presc;
    logic [7:0]  m_psc;
    logic [31:0] m_load, m_count;
    logic        m_irq;

`ifdef MMIO_TIMER_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    mmio_timer dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .writeData (writeData),
        .memWrite  (memWrite),
        .memRead   (memRead),
        .readData  (readData),
        .hit       (hit),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
        m_presc = 0; m_psc = 0; m_load = 0; m_count = 0; m_irq = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a[1:0])
            2'd0:    return {16'd0, m_presc, 5'd0, m_ie, m_auto, m_en};
            2'd1:    return m_load;
            2'd2:    return m_count;
            default: return {30'd0, m_en, m_exp};
        endcase
    endfunction

    // One clock edge of the timer, applied as the prose rules read: hardware tick first, bus overrides after.
    task automatic model_step(input logic w, input logic [7:0] a, input logic [31:0] d);
        logic        bus, tick, expiring;
        logic        n_en, n_auto, n_ie, n_exp;
        logic [7:0]  n_presc, n_psc;
        logic [31:0] n_load, n_count;
        bus  = w && (a[7:2] == 6'h3F);
        tick = m_en && (m_psc == m_presc);
        n_en = m_en; n_auto = m_auto; n_ie = m_ie; n_exp = m_exp;
        n_presc = m_presc; n_load = m_load; n_count = m_count;
        n_psc = !m_en ? 8'd0 : (tick ? 8'd0 : m_psc + 8'd1);
        expiring = 0;
        if (tick && !(bus && a[1:0] == 2'd2)) begin
            if (m_count > 0) n_count = m_count - 1;
            else begin
                expiring = 1;
                if (m_auto) n_count = m_load;
                else        n_en = 0;
            end
        end
        if (bus) begin
            case (a[1:0])
                2'd0: begin
                    n_en = d[0]; n_auto = d[1]; n_presc = d[15:8];
                    if (HAS_IRQ) n_ie = d[2];
                    if (!m_en && d[0]) n_psc = 0;
                end
                2'd1: n_load = d;
                2'd2: begin n_count = d; n_psc = 0; end
                default: if (d[0]) n_exp = 0;
            endcase
        end
        if (expiring) n_exp = 1;
        if (!n_en) n_psc = 0;
        m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_exp = n_exp;
        m_presc = n_presc; m_psc = n_psc; m_load = n_load; m_count = n_count;
        m_irq = HAS_IRQ ? (n_exp & n_ie) : 1'b0;
    endtask

    // Called just after a falling edge: drive, sample mid-cycle, then take the rising edge.
    task automatic do_cycle(input logic w, input logic r, input logic [7:0] a, input logic [31:0] d);
        logic exp_hit;
        memWrite = w; memRead = r; addr = a; writeData = d;
        #2;
        exp_hit = (a[7:2] == 6'h3F);
        check("hit", {31'd0, hit}, {31'd0, exp_hit});
        check("readData", readData, (r && exp_hit) ? model_read(a) : 32'd0);
        check("irq", {31'd0, irq}, {31'd0, m_irq});
        last_rd  = readData;
        last_irq = irq;
        @(posedge clk);
        model_step(w, a, d);
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        do_cycle(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        do_cycle(1'b0, 1'b1, a, 32'd0);
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 8'hFE, 32'd0);
    endtask

    initial begin
        rst = 1'b1; addr = 8'hFC; writeData = 0; memWrite = 0; memRead = 1;
        model_reset();
        #3;
        for (int i = 0; i < 4; i++) begin
            addr = 8'hFC + 8'(i);
            #1;
            check("reset_reg", readData, 32'd0);
        end
        check("reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // One-shot, PRESC=0
        wr(8'hFD, 32'd3);
        wr(8'hFE, 32'd3);
        wr(8'hFC, 32'h1);
        rd(8'hFE); check("os_cnt3", last_rd, 32'd3);
        rd(8'hFE); check("os_cnt2", last_rd, 32'd2);
        rd(8'hFE); check("os_cnt1", last_rd, 32'd1);
        rd(8'hFE); check("os_cnt0", last_rd, 32'd0);
        rd(8'hFF); check("os_status", last_rd, 32'h1);
        rd(8'hFC); check("os_en_clr", last_rd, 32'h0);
        wr(8'hFF, 32'h1);

        // Auto-reload with PRESC=2, then W1C race
        wr(8'hFD, 32'd2);
        wr(8'hFE, 32'd2);
        wr(8'hFC, 32'h0203);
        for (int k = 0; k < 9; k++) begin
            rd(8'hFF); check("ar_not_yet", last_rd, 32'h2);
        end
        rd(8'hFE); check("ar_reload", last_rd, 32'd2);
        rd(8'hFF); check("ar_expired", last_rd, 32'h3);
        for (int k = 0; k < 6; k++) idle();
        wr(8'hFF, 32'h1);
        rd(8'hFF); check("w1c_race", last_rd, 32'h3);
        wr(8'hFF, 32'h1);
        rd(8'hFF); check("w1c_clear", last_rd, 32'h2);
        wr(8'hFC, 32'h0);
        wr(8'hFF, 32'h1);

        // Address decode
        wr(8'hF8, 32'hDEADBEEF);
        rd(8'hFD); check("miss_load", last_rd, 32'd2);
        rd(8'hF9); check("miss_read", last_rd, 32'd0);
        wr(8'hFD, 32'hDEADBEEF);
        rd(8'hFD); check("hit_load", last_rd, 32'hDEADBEEF);
        do_cycle(1'b0, 1'b0, 8'hFD, 32'd0); check("no_rd", last_rd, 32'd0);

        // Interrupt
        wr(8'hFD, 32'd1);
        wr(8'hFE, 32'd1);
        wr(8'hFC, 32'h5);
        rd(8'hFC); check("irq_ctrl", last_rd, HAS_IRQ ? 32'h5 : 32'h1);
        check("irq_low0", {31'd0, last_irq}, 32'd0);
        idle();    check("irq_low1", {31'd0, last_irq}, 32'd0);
        idle();    check("irq_rise", {31'd0, last_irq}, {31'd0, HAS_IRQ});
        wr(8'hFF, 32'h1);
        rd(8'hFF); check("irq_fall", {31'd0, last_irq}, 32'd0);
        check("irq_stat", last_rd, 32'h0);

        // Asynchronous reset mid-count
        wr(8'hFD, 32'd100);
        wr(8'hFE, 32'd5);
        wr(8'hFC, 32'h1);
        idle();
        @(posedge clk);
        model_step(1'b0, 8'hFE, 32'd0);
        #3;
        rst = 1'b1;
        model_reset();
        memRead = 1'b1; memWrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = 8'hFC + 8'(i);
            #0.5;
            check("mid_rst_reg", readData, 32'd0);
        end
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic, mostly inside the window with small periods so events collide often
        for (int n = 0; n < 3000; n++) begin
            logic [7:0]  a;
            logic [31:0] d;
            int          op;
            a  = {5'b11111, 3'($urandom_range(0, 7))};
            op = $urandom_range(0, 9);
            case (a[1:0])
                2'd0:    d = {$urandom_range(0, 3) == 0 ? 8'($urandom) : 8'd0, 8'($urandom_range(0, 3)), 8'($urandom)};
                2'd1,
                2'd2:    d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
                default: d = $urandom;
            endcase
            if (op < 2)      wr(a, d);
            else if (op < 8) rd(a);
            else             idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
